// File: rtl/shift_word_deser.sv
// Serial-to-parallel receive stage: start-bit framing, WIDTH-bit word assembly, 2-entry output FIFO.
// Optional macro DESER_PARITY_EN adds an even-parity bit per frame and a per-word par_err flag.
module shift_word_deser #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             lsb_first,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             par_err,
    output logic             busy,
    output logic             overflow,
    input  logic             clr_ovf,
    output logic [CNT_W-1:0] frame_count
);

    localparam int BC_W = $clog2(WIDTH + 1);

`ifdef DESER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic              lsb_q, lsb_d;
    logic [WIDTH-1:0]  shifted;
    logic              push;
    logic [WIDTH-1:0]  push_data;

    logic [WIDTH-1:0]  mem_q [2];
    logic [WIDTH-1:0]  mem_d [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]  hold_data_q, hold_data_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  fcnt_q, fcnt_d;
    logic              pop, accept, drop;

    // Shifting toward the LSB leaves the first-received bit at word[0] after WIDTH captures.
    assign shifted = lsb_q ? {ser_in, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], ser_in};

`ifdef DESER_PARITY_EN
    logic              push_perr;
    logic              perr_q [2];
    logic              perr_d [2];
    logic              hold_perr_q, hold_perr_d;

    assign push_data = sr_q;
`else
    assign push_data = shifted;
`endif

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        lsb_d     = lsb_q;
        push      = 1'b0;
`ifdef DESER_PARITY_EN
        push_perr = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (ser_valid && ser_in) begin
                    state_d   = SHIFT;
                    sr_d      = '0;
                    bit_cnt_d = '0;
                    lsb_d     = lsb_first;
                end
            end
            SHIFT: begin
                if (ser_valid) begin
                    sr_d      = shifted;
                    bit_cnt_d = bit_cnt_q + BC_W'(1);
                    if (bit_cnt_q == BC_W'(WIDTH - 1)) begin
`ifdef DESER_PARITY_EN
                        state_d = PARITY;
`else
                        push    = 1'b1;
                        state_d = IDLE;
`endif
                    end
                end
            end
`ifdef DESER_PARITY_EN
            PARITY: begin
                if (ser_valid) begin
                    push      = 1'b1;
                    push_perr = (^sr_q) ^ ser_in;
                    state_d   = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign out_valid = (cnt_q != 2'd0);
    assign pop       = out_valid & out_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign accept    = push && ((cnt_q != 2'd2) || pop);
    assign drop      = push && (cnt_q == 2'd2) && !pop;

    always_comb begin
        mem_d = mem_q;
        if (accept) mem_d[wr_ptr_q] = push_data;
        rd_ptr_d    = rd_ptr_q ^ pop;
        wr_ptr_d    = wr_ptr_q ^ accept;
        hold_data_d = pop ? mem_q[rd_ptr_q] : hold_data_q;
        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        ovf_d = ovf_q;
        if (clr_ovf) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
        fcnt_d = accept ? fcnt_q + CNT_W'(1) : fcnt_q;
    end

`ifdef DESER_PARITY_EN
    always_comb begin
        perr_d = perr_q;
        if (accept) perr_d[wr_ptr_q] = push_perr;
        hold_perr_d = pop ? perr_q[rd_ptr_q] : hold_perr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perr_q[0]   <= 1'b0;
            perr_q[1]   <= 1'b0;
            hold_perr_q <= 1'b0;
        end else begin
            perr_q      <= perr_d;
            hold_perr_q <= hold_perr_d;
        end
    end

    assign par_err = out_valid ? perr_q[rd_ptr_q] : hold_perr_q;
`else
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            lsb_q       <= 1'b0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
            hold_data_q <= '0;
            ovf_q       <= 1'b0;
            fcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            lsb_q       <= lsb_d;
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            hold_data_q <= hold_data_d;
            ovf_q       <= ovf_d;
            fcnt_q      <= fcnt_d;
        end
    end

    // With the FIFO empty the outputs keep showing the last word that left.
    assign out_data    = out_valid ? mem_q[rd_ptr_q] : hold_data_q;
    assign busy        = (state_q != IDLE);
    assign overflow    = ovf_q;
    assign frame_count = fcnt_q;

endmodule

// File: tb/tb_shift_word_deser.sv
// Directed bench for shift_word_deser with a scoreboard of expected {par_err, word} entries.
module tb_shift_word_deser;
    localparam int W  = 4;
    localparam int CW = 8;
`ifdef DESER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ser_in = 1'b0;
    logic          ser_valid = 1'b0;
    logic          lsb_first = 1'b0;
    logic          out_ready = 1'b0;
    logic          clr_ovf = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          par_err;
    logic          busy;
    logic          overflow;
    logic [CW-1:0] frame_count;

    int checks = 0;
    int errors = 0;
    logic [W:0] sb_q[$];
    logic [W:0] mon_exp;

    shift_word_deser #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .ser_in(ser_in), .ser_valid(ser_valid),
        .lsb_first(lsb_first), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .par_err(par_err), .busy(busy),
        .overflow(overflow), .clr_ovf(clr_ovf), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every handshake the DUT completes is compared against the scoreboard head.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                mon_exp = sb_q.pop_front();
                chk("pop_data", 32'(out_data), 32'(mon_exp[W-1:0]));
                chk("pop_perr", 32'(par_err), 32'(mon_exp[W]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        ser_valid = 1'b1;
        ser_in    = b;
        tick();
        ser_valid = 1'b0;
        ser_in    = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] word, input logic lsb, input int gap,
                              input logic bad_par, input logic expect_push);
        logic perr_exp;
        perr_exp  = PAR_EN && bad_par;
        lsb_first = lsb;
        drive_bit(1'b1);
        lsb_first = ~lsb;
        for (int k = 0; k < W; k++) begin
            if (k > 0) begin
                for (int g = 0; g < gap; g++) begin
                    chk("busy_gap", 32'(busy), 32'd1);
                    tick();
                end
            end
            drive_bit(lsb ? word[k] : word[W-1-k]);
        end
`ifdef DESER_PARITY_EN
        drive_bit((^word) ^ bad_par);
`endif
        if (expect_push) sb_q.push_back({perr_exp, word});
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) tick();
        out_ready = 1'b0;
        chk({tag, "_drained"}, 32'(sb_q.size()), 32'd0);
        @(negedge clk);
        chk({tag, "_empty"}, 32'(out_valid), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        sb_q.delete();
        tick();
    endtask

    initial begin
        logic [W-1:0] w9;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_par_err", 32'(par_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        reset = 1'b1;
        tick();

        // Stream 1,1,0,1,1 LSB-first: data bits 1,0,1,1 -> word 4'b1101.
        send_frame(4'hD, 1'b1, 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'hD);
        chk("t1_count", 32'(frame_count), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);
        drain("t1");
        chk("t1_hold", 32'(out_data), 32'hD);

        // Same stream MSB-first with 2-cycle gaps -> word 4'b1011.
        send_frame(4'hB, 1'b0, 2, 1'b0, 1'b1);
        @(negedge clk);
        chk("t2_data", 32'(out_data), 32'hB);
        chk("t2_count", 32'(frame_count), 32'd2);
        drain("t2");

        // Three back-to-back frames into a stalled consumer; the third is dropped.
        do_reset();
        send_frame(4'h3, 1'b1, 0, 1'b0, 1'b1);
        send_frame(4'h5, 1'b1, 0, 1'b0, 1'b1);
        send_frame(4'h9, 1'b1, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_count", 32'(frame_count), 32'd2);
        chk("t3_head", 32'(out_data), 32'h3);
        drain("t3");
        chk("t3_ovf_sticky", 32'(overflow), 32'd1);
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        @(negedge clk);
        chk("t3_ovf_clr", 32'(overflow), 32'd0);

        // Final capture of the third frame coincides with a pop on a full FIFO.
        do_reset();
        send_frame(4'h3, 1'b1, 0, 1'b0, 1'b1);
        send_frame(4'h5, 1'b1, 0, 1'b0, 1'b1);
        w9 = 4'h9;
        lsb_first = 1'b1;
        drive_bit(1'b1);
        for (int k = 0; k < W - 1; k++) drive_bit(w9[k]);
        sb_q.push_back({1'b0, w9});
        ser_valid = 1'b1;
`ifdef DESER_PARITY_EN
        drive_bit(w9[W-1]);
        ser_valid = 1'b1;
        ser_in    = ^w9;
`else
        ser_in    = w9[W-1];
`endif
        out_ready = 1'b1;
        tick();
        ser_valid = 1'b0;
        ser_in    = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("t4_overflow", 32'(overflow), 32'd0);
        chk("t4_count", 32'(frame_count), 32'd3);
        chk("t4_head", 32'(out_data), 32'h5);
        drain("t4");

        // Reset mid-frame discards the partial word.
        do_reset();
        lsb_first = 1'b1;
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        send_frame(4'hA, 1'b1, 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("t5_count", 32'(frame_count), 32'd1);
        chk("t5_data", 32'(out_data), 32'hA);
        drain("t5");

`ifdef DESER_PARITY_EN
        do_reset();
        send_frame(4'h7, 1'b1, 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("t6_perr_ok", 32'(par_err), 32'd0);
        drain("t6a");
        send_frame(4'h7, 1'b1, 0, 1'b1, 1'b1);
        @(negedge clk);
        chk("t6_perr_bad", 32'(par_err), 32'd1);
        chk("t6_data", 32'(out_data), 32'h7);
        drain("t6b");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
